uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 serial transmitter driving the board `tx` line toward the host.
- Complements the wired echo/`rx` path: the host side stops seeing a loopback and now receives bytes generated by the FPGA.
- Contains its own baud tick generator and a load/ready handshake with the user logic.
- Target clock: 12 MHz board clock.

Parameters:
- BAUD, 104, clock cycles per bit. 104 gives 115200 baud at 12 MHz. Legal range is 2 to 65535.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request to send `data`. Sampled on clk rising edge.
- data  in  8  byte to transmit. Captured in the cycle `start` is accepted.
- tx  out  1  serial line. Idles high.
- ready  out  1  high when idle and able to accept `start`.

Behaviour:
- Reset (rstn=0, takes effect immediately regardless of clk):
  - tx=1, ready=1, FSM in IDLE.
  - Baud counter and bit counter cleared. Shift register cleared.
- Reset mid-frame: the frame is aborted. tx returns high at once, with no partial stop bit. After release the block is in IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: ready=1, tx=1. When start=1 on a clk edge: latch data into the shift register, clear the baud counter, go to START. ready=0 and tx=0 from that edge onward.
  - START: tx=0 for exactly BAUD cycles, then go to DATA with bit counter=0.
  - DATA: tx = shift register bit 0, LSB first. Each bit is held BAUD cycles, then the register shifts right. After bit 7 completes, go to STOP.
  - STOP: tx=1 for BAUD cycles, then go to IDLE. ready=1 on the following edge.
- Timing: the frame occupies exactly 10*BAUD cycles from the accepting edge. ready is low for exactly 10*BAUD cycles.
- Baud counter:
  - Counts 0..BAUD-1 and wraps.
  - The tick fires at count BAUD-1.
  - The counter runs only outside IDLE and restarts at 0 on acceptance, so the first bit is never short.
- start while ready=0 is ignored: it is neither queued nor latched. data changes during a frame have no effect.
- start held continuously high:
  - After STOP, ready stays high for exactly one cycle, then the next frame is accepted.
  - tx therefore idles high for 1 cycle between frames, giving an inter-frame gap of BAUD+1 high cycles including the stop bit.
- tx is registered (driven from a flop), so it is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx = XOR of the 8 latched data bits (even parity) for BAUD cycles.
  - Frame and ready-low time become 11*BAUD cycles.
- Undefined: no PARITY state, 10*BAUD frame, logic absent.

Decomposition:
- Package uart_pkg:
  - Baud divisor constants for 12 MHz: B115200=104, B57600=208, B38400=313, B19200=625, B9600=1250.
  - FSM state encoding: IDLE, START, DATA, STOP, and PARITY when enabled.
  - Frame length constant.
- Sub-module baudgen_tx(clk, rstn, clk_ena, clk_out):
  - Parameter BAUD.
  - clk_out is a one-cycle pulse every BAUD cycles while clk_ena=1.
  - Counter held at 0 while clk_ena=0.
  - Reused later by the receiver.

Test Plan (BAUD=4 unless stated):
- Send 0x41:
  - start pulsed 1 cycle with data=0x41.
  - tx = 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles.
  - ready low exactly 40 cycles, then high.
- Busy rejection:
  - During the 0x41 frame, pulse start with data=0xFF at cycle 10.
  - Frame bits unchanged. No second frame follows. ready stays high afterwards.
- Back-to-back:
  - start held high, data=0x55.
  - Two frames, each 40 cycles.
  - ready high for exactly 1 cycle between them.
  - tx high for 5 consecutive cycles at the join (stop bit plus 1 idle cycle).
- Reset mid-frame:
  - Drop rstn at cycle 17 of a 0x00 frame, asynchronously between edges.
  - tx=1 and ready=1 within the same timestep.
  - After release, send 0xA5: correct full 40-cycle frame.
- Parity (UART_TX_PARITY_EN defined):
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Each frame is 44 cycles.
- Real divisor (BAUD=104):
  - Send 0x0D.
  - Start-bit falling edge to stop-bit end is 1040 cycles. Each bit is 104±0 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART transmit path
// Purpose: baud divisors for a 12 MHz clock, TX FSM state encoding and frame length.
// Ports: none (package).
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit to the frame.
package uart_pkg;

  // Clock cycles per bit at 12 MHz.
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  function automatic int frame_cycles(input int baud);
    return FRAME_BITS * baud;
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - load/ready handshake between user logic and the UART transmitter
// Purpose: groups the byte-load handshake signals.
// Signals: start (request to send), data (byte to send), ready (transmitter idle).
// Modports: master = user logic, slave = transmitter.
interface uart_tx_if;
  logic       start;
  logic [7:0] data;
  logic       ready;

  modport master (output start, output data, input ready);
  modport slave  (input start, input data, output ready);
endinterface

// File: rtl/baudgen_tx.sv
// rtl/baudgen_tx.sv - bit-period tick generator
// Purpose: one-cycle pulse every BAUD clocks while enabled; counter parked at 0 when disabled,
//          so the first period after enabling is always a full BAUD cycles.
// Ports: clk, rstn (async active-low), clk_ena (run counter), clk_out (tick pulse).
module baudgen_tx #(
  parameter int BAUD = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic clk_ena,
  output logic clk_out
);

  localparam logic [15:0] LAST = 16'(BAUD - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    clk_out = clk_ena && (cnt_q == LAST);
    cnt_d   = 16'd0;
    if (clk_ena && !clk_out) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with load/ready handshake
// Purpose: serialises one byte per accepted start as start bit, 8 data bits LSB first, stop bit.
// Ports: clk, rstn (async active-low), bus (uart_tx_if.slave: start, data, ready), tx (serial out, idles high).
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  uart_tx_if.slave   bus,
  output logic       tx
);

  tx_state_e   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        tx_q, tx_d;
  logic        baud_tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  baudgen_tx #(.BAUD(BAUD)) u_baudgen (
    .clk     (clk),
    .rstn    (rstn),
    .clk_ena (state_q != ST_IDLE),
    .clk_out (baud_tick)
  );

  assign bus.ready = (state_q == ST_IDLE);
  assign tx        = tx_q;

  // tx_d always carries the level of the bit about to start, so tx stays a pure flop output.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (bus.start) begin
          shreg_d = bus.data;
          state_d = ST_START;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(bus.data);
`endif
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      shreg_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (BAUD=4 and BAUD=104 instances)
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BA = 4;
  localparam int BB = 104;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk;
  logic rstn;
  logic tx_a, tx_b;
  int   total = 0;
  int   bad   = 0;

  uart_tx_if if_a();
  uart_tx_if if_b();

  uart_tx #(.BAUD(BA)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a.slave), .tx(tx_a));
  uart_tx #(.BAUD(BB)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b.slave), .tx(tx_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] base;   // {stop, d7..d0, start}, bit 0 sent first
    logic       par;    // even parity of data
    int         inject; // cycle at which a rejected start(0xFF) arrives, -1 = none
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] d);
    if (sel) begin
      if_b.start = s; if_b.data = d;
    end else begin
      if_a.start = s; if_a.data = d;
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic cur_rdy(input bit sel);
    return sel ? if_b.ready : if_a.ready;
  endfunction

  function automatic logic [10:0] make_seq(input logic [9:0] base, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, base[8:0]};
`else
    return {par & 1'b0, base};
`endif
  endfunction

  task automatic run_frame(input bit sel, input logic [7:0] d, input logic [9:0] base,
                           input logic par, input int inject, input string nm);
    int b;
    logic [10:0] sq;
    b  = sel ? BB : BA;
    sq = make_seq(base, par);
    @(negedge clk);
    drive(sel, 1'b1, d);
    @(posedge clk);
    #1 drive(sel, 1'b0, ~d);
    for (int c = 0; c < NB * b; c++) begin
      @(negedge clk);
      check($sformatf("%s tx c%0d", nm, c), 32'(cur_tx(sel)), 32'(sq[c / b]));
      check($sformatf("%s ready c%0d", nm, c), 32'(cur_rdy(sel)), 32'd0);
      if (c == inject - 1) drive(sel, 1'b1, 8'hFF);
      if (c == inject)     drive(sel, 1'b0, 8'h00);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("%s idle ready +%0d", nm, c), 32'(cur_rdy(sel)), 32'd1);
      check($sformatf("%s idle tx +%0d", nm, c), 32'(cur_tx(sel)), 32'd1);
    end
  endtask

  logic ts [0:2*NB*BA+1];
  logic rs [0:2*NB*BA+1];

  initial begin
    logic [10:0] sq;
    int hi_run, rdy_cnt;

    vecs[0] = '{8'h41, {1'b1, 8'h41, 1'b0}, 1'b0, -1, "send41"};
    vecs[1] = '{8'h41, {1'b1, 8'h41, 1'b0}, 1'b0, 10, "busy41"};
    vecs[2] = '{8'h07, {1'b1, 8'h07, 1'b0}, 1'b1, -1, "send07"};
    vecs[3] = '{8'h03, {1'b1, 8'h03, 1'b0}, 1'b0, -1, "send03"};
    vecs[4] = '{8'hFF, {1'b1, 8'hFF, 1'b0}, 1'b0, -1, "sendFF"};
    vecs[5] = '{8'h80, {1'b1, 8'h80, 1'b0}, 1'b1, -1, "send80"};

    rstn = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx_a), 32'd1);
    check("reset ready", 32'(if_a.ready), 32'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset tx", 32'(tx_a), 32'd1);
    check("post-reset ready", 32'(if_a.ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_frame(1'b0, vecs[i].data, vecs[i].base, vecs[i].par, vecs[i].inject, vecs[i].name);
    end

    // Back-to-back with start held high, data 0x55.
    sq = make_seq({1'b1, 8'h55, 1'b0}, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h55);
    @(posedge clk);
    for (int c = 0; c <= 2 * NB * BA + 1; c++) begin
      @(negedge clk);
      ts[c] = tx_a;
      rs[c] = if_a.ready;
      if (c == NB * BA + 1) drive(1'b0, 1'b0, 8'h00);
    end
    for (int c = 0; c < NB * BA; c++) begin
      check($sformatf("b2b f1 tx c%0d", c), 32'(ts[c]), 32'(sq[c / BA]));
      check($sformatf("b2b f2 tx c%0d", c), 32'(ts[c + NB * BA + 1]), 32'(sq[c / BA]));
    end
    rdy_cnt = 0;
    for (int c = 0; c <= 2 * NB * BA; c++) if (rs[c]) rdy_cnt++;
    check("b2b ready-high cycles between frames", 32'(rdy_cnt), 32'd1);
    check("b2b ready gap position", 32'(rs[NB * BA]), 32'd1);
    check("b2b ready after second frame", 32'(rs[2 * NB * BA + 1]), 32'd1);
    hi_run = 0;
    for (int c = NB * BA; c >= 0; c--) begin
      if (!ts[c]) break;
      hi_run++;
    end
    check("b2b tx high run at join", 32'(hi_run), 32'(BA + 1));
    check("b2b second start bit", 32'(ts[NB * BA + 1]), 32'd0);

    // Asynchronous reset in the middle of a 0x00 frame.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h00);
    repeat (17) @(posedge clk);
    #2;
    check("midframe tx before reset", 32'(tx_a), 32'd0);
    rstn = 1'b0;
    #1;
    check("midframe reset tx", 32'(tx_a), 32'd1);
    check("midframe reset ready", 32'(if_a.ready), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("after reset ready", 32'(if_a.ready), 32'd1);
    check("after reset tx", 32'(tx_a), 32'd1);
    run_frame(1'b0, 8'hA5, {1'b1, 8'hA5, 1'b0}, 1'b0, -1, "postrst A5");

    // Real divisor.
    run_frame(1'b1, 8'h0D, {1'b1, 8'h0D, 1'b0}, 1'b1, -1, "baud104 0D");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
